alu_scheduler: RTL and testbench

- Sequencer and arbiter that shares one `alu` instance between two requesters.
- Per requester: accepts an operation request through a valid/ready handshake.
- Drives the ALU operand, select and init inputs, then waits the correct latency. The add/sub path is combinational; the multiplier uses an init/done handshake.
- Returns the result, tagged with the requester ID, on one shared response channel with backpressure.

---
 rtl/alu_scheduler_if.sv | 24 ++
 rtl/alu_scheduler.sv | 85 ++++++++
 tb/tb_alu_scheduler.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_scheduler_if.sv
// alu_scheduler_if: request, alu and response channels of the shared-alu scheduler
interface alu_scheduler_if;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_A, req0_B, req1_A, req1_B;
    logic [1:0] req0_op, req1_op;
    logic [3:0] alu_A, alu_B;
    logic [1:0] alu_Select;
    logic       alu_Init, alu_Cout, alu_Done;
    logic [7:0] alu_Sal;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_err, busy;
    logic [7:0] rsp_data;
    modport master (
        output req0_valid, req0_A, req0_B, req0_op, req1_valid, req1_A, req1_B, req1_op,
        output alu_Sal, alu_Cout, alu_Done, rsp_ready,
        input  req0_ready, req1_ready, alu_A, alu_B, alu_Select, alu_Init,
        input  rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_err, busy
    );
    modport slave (
        input  req0_valid, req0_A, req0_B, req0_op, req1_valid, req1_A, req1_B, req1_op,
        input  alu_Sal, alu_Cout, alu_Done, rsp_ready,
        output req0_ready, req1_ready, alu_A, alu_B, alu_Select, alu_Init,
        output rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_err, busy
    );
endinterface

// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin sequencer sharing one alu between two requesters
module alu_scheduler #(
    parameter int MUL_TIMEOUT = 16,
    parameter int CNT_W = 5
) (
    input logic Clk,
    input logic Rst,
    alu_scheduler_if.slave bus
);
    typedef enum logic [2:0] {IDLE, EXEC, MUL_INIT, MUL_WAIT, RESP} state_t;
    state_t state;
    logic rr_ptr, g0, g1;
    logic [CNT_W-1:0] cnt;
    logic [3:0] a, b;
    logic [1:0] op;
    assign g0 = bus.req0_valid && (!bus.req1_valid || !rr_ptr);
    assign g1 = bus.req1_valid && (!bus.req0_valid || rr_ptr);
    assign bus.req0_ready = state == IDLE && g0;
    assign bus.req1_ready = state == IDLE && g1;
    assign bus.rsp_valid = state == RESP;
    assign bus.busy = state != IDLE;
    assign a = g1 ? bus.req1_A : bus.req0_A;
    assign b = g1 ? bus.req1_B : bus.req0_B;
    assign op = g1 ? bus.req1_op : bus.req0_op;
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            rr_ptr <= 1'b0;
            cnt <= '0;
            bus.alu_A <= '0;
            bus.alu_B <= '0;
            bus.alu_Select <= '0;
            bus.alu_Init <= 1'b0;
            bus.rsp_id <= 1'b0;
            bus.rsp_data <= '0;
            bus.rsp_cout <= 1'b0;
            bus.rsp_err <= 1'b0;
        end else begin
            bus.alu_Init <= 1'b0;
            case (state)
                IDLE: if (g0 || g1) begin
                    bus.alu_A <= a;
                    bus.alu_B <= b;
                    bus.alu_Select <= op;
                    bus.alu_Init <= op == 2'd2;
                    bus.rsp_id <= g1;
                    bus.rsp_data <= '0;
                    bus.rsp_cout <= 1'b0;
                    bus.rsp_err <= op == 2'd3;
                    state <= op == 2'd3 ? RESP : op[1] ? MUL_INIT : EXEC;
                end
                EXEC: begin
                    bus.rsp_data <= bus.alu_Sal;
                    bus.rsp_cout <= bus.alu_Cout;
                    bus.rsp_err <= 1'b0;
                    state <= RESP;
                end
                MUL_INIT: begin
                    cnt <= '0;
                    state <= MUL_WAIT;
                end
                MUL_WAIT: begin
                    cnt <= cnt + 1'b1;
                    // the first wait cycle ignores done so a stale pulse cannot complete the op
                    if (cnt != '0 && bus.alu_Done) begin
                        bus.rsp_data <= bus.alu_Sal;
                        bus.rsp_cout <= 1'b0;
                        bus.rsp_err <= 1'b0;
                        state <= RESP;
                    end else if (cnt == CNT_W'(MUL_TIMEOUT - 1)) begin
                        bus.rsp_data <= '0;
                        bus.rsp_cout <= 1'b0;
                        bus.rsp_err <= 1'b1;
                        state <= RESP;
                    end
                end
                RESP: if (bus.rsp_ready) begin
                    rr_ptr <= ~bus.rsp_id;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: directed scoreboard bench with a behavioural alu and delayed multiplier done
module tb_alu_scheduler;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;
    alu_scheduler_if bus();
    alu_scheduler #(.MUL_TIMEOUT(16), .CNT_W(5)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

    typedef struct {logic id; logic [7:0] data; logic cout; logic err; int lat; int acc;} exp_t;
    exp_t q[$];
    exp_t e;
    logic gq[$];
    logic g;
    int tests = 0, fails = 0, cyc = 0, init_cnt = 0, dcnt = 0, n;
    logic hang = 1'b0, prev_v = 1'b0;
    logic [8:0] alu_o;

    function automatic logic [8:0] alu_model(input logic [1:0] s, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] r;
        r = s == 2'd1 ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
        return s == 2'd2 ? {1'b1, 8'(a) * 8'(b)} : {r[4], 4'h0, r[3:0]};
    endfunction

    assign alu_o = alu_model(bus.alu_Select, bus.alu_A, bus.alu_B);
    assign bus.alu_Sal = alu_o[7:0];
    assign bus.alu_Cout = alu_o[8];

    // multiplier raises done for one cycle, nine cycles after the init cycle
    always @(posedge Clk) begin
        if (bus.alu_Init) dcnt <= 8;
        else if (dcnt != 0) dcnt <= dcnt - 1;
        bus.alu_Done <= dcnt == 1 && !hang;
    end

    task automatic accept(input logic id, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        exp_t x;
        logic [8:0] r;
        r = alu_model(op, a, b);
        x.id = id;
        x.acc = cyc;
        x.err = op == 2'd3 || (op == 2'd2 && hang);
        x.data = x.err ? 8'h00 : r[7:0];
        x.cout = op[1] ? 1'b0 : r[8];
        x.lat = op == 2'd3 ? 1 : op == 2'd2 ? (hang ? 18 : 11) : 2;
        q.push_back(x);
        if (gq.size() != 0) begin
            g = gq.pop_front();
            tests++;
            assert (id === g) else begin fails++; $error("FAIL grant_order got %0d want %0d", id, g); end
        end
    endtask

    always @(negedge Clk) begin
        cyc++;
        if (bus.alu_Init) init_cnt++;
        if (Rst) prev_v = 1'b0;
        else begin
            if (bus.req0_valid && bus.req0_ready) accept(1'b0, bus.req0_A, bus.req0_B, bus.req0_op);
            if (bus.req1_valid && bus.req1_ready) accept(1'b1, bus.req1_A, bus.req1_B, bus.req1_op);
            if (bus.rsp_valid && !prev_v) begin
                tests++;
                assert (q.size() != 0 && cyc - q[0].acc == q[0].lat) else begin
                    fails++;
                    $error("FAIL latency got %0d want %0d", q.size() != 0 ? cyc - q[0].acc : -1, q.size() != 0 ? q[0].lat : -1);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                tests++;
                assert (q.size() != 0) else begin fails++; $error("FAIL unexpected_rsp got id=%0d want none", bus.rsp_id); end
                if (q.size() != 0) begin
                    e = q.pop_front();
                    tests++;
                    assert ({bus.rsp_id, bus.rsp_data, bus.rsp_cout, bus.rsp_err} === {e.id, e.data, e.cout, e.err}) else begin
                        fails++;
                        $error("FAIL rsp got id=%0d data=%h cout=%0d err=%0d want id=%0d data=%h cout=%0d err=%0d",
                               bus.rsp_id, bus.rsp_data, bus.rsp_cout, bus.rsp_err, e.id, e.data, e.cout, e.err);
                    end
                end
            end
            prev_v = bus.rsp_valid && !bus.rsp_ready;
        end
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin fails++; $error("FAIL %s got %h want %h", tag, got, exp); end
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (q.size() != 0 && k < budget) begin
            @(posedge Clk);
            k++;
        end
        #1;
        chk("drain", q.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_alu"}, {bus.alu_A, bus.alu_B, bus.alu_Select, bus.alu_Init}, 0);
        chk({tag, "_rsp"}, {bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_cout, bus.rsp_err}, 0);
        chk({tag, "_ctl"}, {bus.req0_ready, bus.req1_ready, bus.busy}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        {bus.req0_valid, bus.req0_A, bus.req0_B, bus.req0_op} = '0;
        {bus.req1_valid, bus.req1_A, bus.req1_B, bus.req1_op} = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk_zero("reset");
        tick;
        Rst = 1'b0;
        tick;
        // add 3+5 from requester 0
        bus.rsp_ready = 1'b1;
        {bus.req0_valid, bus.req0_A, bus.req0_B, bus.req0_op} = {1'b1, 4'd3, 4'd5, 2'd0};
        @(negedge Clk);
        chk("add_ready0", bus.req0_ready, 1);
        tick;
        bus.req0_valid = 1'b0;
        bus.req0_A = 4'hF;
        @(negedge Clk);
        chk("add_exec", {bus.busy, bus.rsp_valid}, 2'b10);
        chk("add_alu_regs", {bus.alu_A, bus.alu_B, bus.alu_Select}, {4'd3, 4'd5, 2'd0});
        tick;
        @(negedge Clk);
        chk("add_resp", {bus.busy, bus.rsp_valid}, 2'b11);
        tick;
        @(negedge Clk);
        chk("add_idle", {bus.busy, bus.rsp_valid}, 0);
        tick;
        // mul 7*6 from requester 1
        init_cnt = 0;
        {bus.req1_valid, bus.req1_A, bus.req1_B, bus.req1_op} = {1'b1, 4'd7, 4'd6, 2'd2};
        @(negedge Clk);
        chk("mul_ready1", bus.req1_ready, 1);
        tick;
        bus.req1_valid = 1'b0;
        drain(40);
        chk("mul_init_once", init_cnt, 1);
        // reserved opcode with backpressure, requester 1 waiting
        bus.rsp_ready = 1'b0;
        {bus.req0_valid, bus.req0_A, bus.req0_B, bus.req0_op} = {1'b1, 4'd9, 4'd9, 2'd3};
        @(negedge Clk);
        chk("rsv_ready0", bus.req0_ready, 1);
        tick;
        bus.req0_valid = 1'b0;
        {bus.req1_valid, bus.req1_A, bus.req1_B, bus.req1_op} = {1'b1, 4'd9, 4'd8, 2'd0};
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("bp_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_cout, bus.rsp_err}, {1'b1, 1'b0, 8'h00, 1'b0, 1'b1});
            chk("bp_ready", {bus.req0_ready, bus.req1_ready}, 0);
            tick;
        end
        bus.rsp_ready = 1'b1;
        @(negedge Clk);
        chk("hs_no_accept", bus.req1_ready, 0);
        tick;
        @(negedge Clk);
        chk("after_hs_ready1", bus.req1_ready, 1);
        tick;
        bus.req1_valid = 1'b0;
        drain(10);
        // multiplier timeout, then a normal request from requester 0
        hang = 1'b1;
        {bus.req0_valid, bus.req0_A, bus.req0_B, bus.req0_op} = {1'b1, 4'd3, 4'd4, 2'd2};
        @(negedge Clk);
        chk("to_ready0", bus.req0_ready, 1);
        tick;
        bus.req0_valid = 1'b0;
        drain(40);
        hang = 1'b0;
        {bus.req0_valid, bus.req0_A, bus.req0_B, bus.req0_op} = {1'b1, 4'd2, 4'd2, 2'd0};
        @(negedge Clk);
        chk("post_to_ready0", bus.req0_ready, 1);
        tick;
        bus.req0_valid = 1'b0;
        drain(10);
        // reset during MUL_WAIT; the late done must not produce a response
        {bus.req1_valid, bus.req1_A, bus.req1_B, bus.req1_op} = {1'b1, 4'd5, 4'd5, 2'd2};
        @(negedge Clk);
        chk("rmw_ready1", bus.req1_ready, 1);
        tick;
        bus.req1_valid = 1'b0;
        repeat (4) tick;
        @(negedge Clk);
        chk("rmw_busy", {bus.busy, bus.rsp_valid}, 2'b10);
        tick;
        Rst = 1'b1;
        q.delete();
        tick;
        Rst = 1'b0;
        @(negedge Clk);
        chk_zero("midrst");
        repeat (12) begin
            @(negedge Clk);
            chk("no_late_rsp", {bus.rsp_valid, bus.busy}, 0);
        end
        tick;
        // both requesters valid continuously: grants alternate starting at 0
        gq.push_back(1'b0);
        gq.push_back(1'b1);
        gq.push_back(1'b0);
        gq.push_back(1'b1);
        {bus.req0_valid, bus.req0_A, bus.req0_B, bus.req0_op} = {1'b1, 4'd1, 4'd2, 2'd0};
        {bus.req1_valid, bus.req1_A, bus.req1_B, bus.req1_op} = {1'b1, 4'd2, 4'd5, 2'd1};
        n = 0;
        while (gq.size() != 0 && n < 60) begin
            tick;
            n++;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("arb_grants", gq.size(), 0);
        drain(10);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
